// File: rtl/proc_fetch_queue.sv
// Instruction fetch unit with a credit-limited circular fetch queue.
// Redirects flush the queue and drop responses that were still in flight.
module proc_fetch_queue #(
    parameter int unsigned p_depth    = 4,
    parameter logic [31:0] p_reset_pc = 32'h00000000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imemreq_val,
    input  logic                         imemreq_rdy,
    output logic [31:0]                  imemreq_addr,
    input  logic                         imemresp_val,
    input  logic [31:0]                  imemresp_data,
    input  logic                         redirect_val,
    input  logic [31:0]                  redirect_addr,
    output logic                         inst_val,
    input  logic                         inst_rdy,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic [$clog2(p_depth+1)-1:0] count
);

    localparam int unsigned c_cnt_w = $clog2(p_depth + 1);
    localparam int unsigned c_ptr_w = $clog2(p_depth);
    localparam logic [c_cnt_w:0] c_depth_ext = p_depth[c_cnt_w:0];

    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic [c_cnt_w-1:0] outstanding;
    logic [c_cnt_w-1:0] drop_cnt;
    logic [c_ptr_w-1:0] head;
    logic [c_ptr_w-1:0] tail;
    logic [31:0]        queue_pc   [p_depth];
    logic [31:0]        queue_inst [p_depth];

    logic [c_cnt_w:0]   credit_used;
    logic               req_fire;
    logic               resp_accept;
    logic               resp_drop;
    logic               enq;
    logic               deq;

    // Every fetch in flight reserves a queue slot, so the queue can never overflow.
    assign credit_used  = {1'b0, outstanding} + {1'b0, count};
    assign imemreq_val  = !rst && !redirect_val && (credit_used < c_depth_ext);
    assign imemreq_addr = fetch_pc;
    assign req_fire     = imemreq_val && imemreq_rdy;

    // Responses with nothing outstanding are strays from before a reset.
    assign resp_accept  = imemresp_val && (outstanding != '0);
    assign resp_drop    = resp_accept && (redirect_val || (drop_cnt != '0));
    assign enq          = resp_accept && !resp_drop;

    assign inst_val     = !rst && (count != '0) && !redirect_val;
    assign inst         = queue_inst[head];
    assign inst_pc      = queue_pc[head];
    assign deq          = inst_val && inst_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= p_reset_pc;
            resp_pc     <= p_reset_pc;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else begin
            if (req_fire && !resp_accept) begin
                outstanding <= outstanding + 1'b1;
            end else if (!req_fire && resp_accept) begin
                outstanding <= outstanding - 1'b1;
            end

            if (redirect_val) begin
                // The response arriving now is dropped immediately, so it needs no drop credit.
                fetch_pc <= redirect_addr;
                resp_pc  <= redirect_addr;
                drop_cnt <= outstanding - c_cnt_w'(resp_accept);
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_drop && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (enq) begin
                    tail    <= tail + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (deq) begin
                    head <= head + 1'b1;
                end
                if (enq && !deq) begin
                    count <= count + 1'b1;
                end else if (!enq && deq) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            queue_pc[tail]   <= resp_pc;
            queue_inst[tail] <= imemresp_data;
        end
    end

endmodule
